tinymem_sys: RTL and testbench

Memory-side subsystem consumed by the core's `tinymemif` master port. It serves instruction fetches, loads and stores against an on-chip RAM with byte, halfword and word lanes. It also decodes a small MMIO window containing a console transmit FIFO with valid/ready output and a free-running machine timer with compare interrupt. Reads are combinational, so the core latches fetched instructions and load data in the same cycle; all state changes occur on the clock edge.

---
 rtl/tinymem_sys_pkg.sv | 27 ++
 rtl/tinymemif.sv | 22 ++
 rtl/tinymem_sys_console_fifo.sv | 44 ++++
 rtl/tinymem_sys.sv | 150 +++++++++++++++
 tb/tb_tinymem_sys.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tinymem_sys_pkg.sv
// Shared types and MMIO constants for the tinymem memory subsystem.
package definitions;

    typedef enum logic [1:0] {
        MEM_ACCESS_SIZE_BYTE = 2'd0,
        MEM_ACCESS_SIZE_HALF = 2'd1,
        MEM_ACCESS_SIZE_WORD = 2'd2
    } mem_access_size_t;

    localparam logic [11:0] MMIO_CONSOLE_TX   = 12'h000;
    localparam logic [11:0] MMIO_CONSOLE_STAT = 12'h004;
    localparam logic [11:0] MMIO_MTIME        = 12'h008;
    localparam logic [11:0] MMIO_MTIMECMP     = 12'h00C;

    // Size of the decoded MMIO window; offsets beyond the registers read as 0.
    localparam logic [31:0] MMIO_SPAN = 32'h0000_1000;

    function automatic logic is_aligned(mem_access_size_t size, logic [1:0] lsb);
        case (size)
            MEM_ACCESS_SIZE_BYTE: return 1'b1;
            MEM_ACCESS_SIZE_HALF: return ~lsb[0];
            MEM_ACCESS_SIZE_WORD: return lsb == 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tinymemif.sv
// Core-to-memory port: combinational read channel plus a single write channel.
interface tinymemif;

    logic [31:0]                  rd_addr;
    definitions::mem_access_size_t rd_size;
    logic [31:0]                  rd_data;
    logic [31:0]                  wr_addr;
    logic [31:0]                  wr_data;
    definitions::mem_access_size_t wr_size;
    logic                         wr_enable;

    modport master (
        output rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
        input  rd_data
    );

    modport slave (
        input  rd_addr, rd_size, wr_addr, wr_data, wr_size, wr_enable,
        output rd_data
    );

endinterface

// File: rtl/tinymem_sys_console_fifo.sv
// Console transmit FIFO: synchronous push/pop, head byte reads 0 when empty.
module console_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty_o = wr_ptr == rd_ptr;
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/tinymem_sys.sv
// On-chip RAM with byte lanes plus MMIO console FIFO and machine timer,
// serving the core's tinymemif master port with zero-latency reads.
module tinymem_sys
  import definitions::*;
#(
  parameter logic [31:0] MEM_BASE   = 32'h0001_0000,
  parameter int unsigned MEM_WORDS  = 16384,
  parameter              INIT_FILE  = "",
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  tinymemif.slave    memif,
  output logic [7:0] console_data_o,
  output logic       console_valid_o,
  input  logic       console_ready_i,
  output logic       timer_irq_o,
  output logic       err_o
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0] ram [MEM_WORDS];

  logic [31:0] mtime;
  logic [31:0] mtimecmp;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  // Read-side decode
  logic [31:0] rd_off;
  logic [31:0] rd_moff;
  logic        rd_in_ram;
  logic        rd_in_mmio;
  logic        rd_ok;
  logic [31:0] rd_word;

  assign rd_off     = memif.rd_addr - MEM_BASE;
  assign rd_moff    = memif.rd_addr - MMIO_BASE;
  assign rd_in_ram  = rd_off < RAM_BYTES;
  assign rd_in_mmio = rd_moff < MMIO_SPAN;
  assign rd_ok      = is_aligned(memif.rd_size, memif.rd_addr[1:0]) &&
                      (rd_in_ram || (rd_in_mmio && memif.rd_size == MEM_ACCESS_SIZE_WORD));
  assign rd_word    = ram[rd_off[IDX_W+1:2]];

  always_comb begin
    memif.rd_data = '0;
    if (rd_ok && rd_in_ram) begin
      case (memif.rd_size)
        MEM_ACCESS_SIZE_BYTE: memif.rd_data = {24'b0, rd_word[{rd_off[1:0], 3'b000} +: 8]};
        MEM_ACCESS_SIZE_HALF: memif.rd_data = {16'b0, rd_off[1] ? rd_word[31:16] : rd_word[15:0]};
        default:              memif.rd_data = rd_word;
      endcase
    end else if (rd_ok) begin
      case (rd_moff[11:0])
        MMIO_CONSOLE_STAT: memif.rd_data = {30'b0, fifo_full, fifo_empty};
        MMIO_MTIME:        memif.rd_data = mtime;
        MMIO_MTIMECMP:     memif.rd_data = mtimecmp;
        default:           memif.rd_data = '0;
      endcase
    end
  end

  // Write-side decode
  logic [31:0] wr_off;
  logic [31:0] wr_moff;
  logic        wr_aligned;
  logic        ram_we;
  logic        mmio_we;
  logic        tx_push;
  logic        mtime_we;
  logic        mtimecmp_we;
  logic [3:0]  lane_be;
  logic [31:0] lane_data;

  assign wr_off      = memif.wr_addr - MEM_BASE;
  assign wr_moff     = memif.wr_addr - MMIO_BASE;
  assign wr_aligned  = is_aligned(memif.wr_size, memif.wr_addr[1:0]);
  assign ram_we      = memif.wr_enable && wr_aligned && (wr_off < RAM_BYTES);
  assign mmio_we     = memif.wr_enable && wr_aligned && (wr_moff < MMIO_SPAN) &&
                       memif.wr_size == MEM_ACCESS_SIZE_WORD;
  assign tx_push     = mmio_we && wr_moff[11:0] == MMIO_CONSOLE_TX;
  assign mtime_we    = mmio_we && wr_moff[11:0] == MMIO_MTIME;
  assign mtimecmp_we = mmio_we && wr_moff[11:0] == MMIO_MTIMECMP;

  // Replicate the low bytes of wr_data across lanes; lane_be picks the live ones.
  always_comb begin
    lane_be   = 4'b0000;
    lane_data = memif.wr_data;
    case (memif.wr_size)
      MEM_ACCESS_SIZE_BYTE: begin
        lane_be   = 4'b0001 << wr_off[1:0];
        lane_data = {4{memif.wr_data[7:0]}};
      end
      MEM_ACCESS_SIZE_HALF: begin
        lane_be   = wr_off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{memif.wr_data[15:0]}};
      end
      MEM_ACCESS_SIZE_WORD: lane_be = 4'b1111;
      default:              lane_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_be[i]) ram[wr_off[IDX_W+1:2]][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (tx_push),
    .push_data_i (memif.wr_data[7:0]),
    .pop_i       (console_ready_i),
    .head_o      (console_data_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign console_valid_o = ~fifo_empty;
  assign fifo_pop        = console_ready_i && ~fifo_empty;

  logic set_err;
  assign set_err = ~rd_ok ||
                   (memif.wr_enable && !(ram_we || mmio_we)) ||
                   (tx_push && fifo_full && !fifo_pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mtime       <= '0;
      mtimecmp    <= '1;
      timer_irq_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      mtime       <= mtime_we ? memif.wr_data : mtime + 32'd1;
      if (mtimecmp_we) mtimecmp <= memif.wr_data;
      timer_irq_o <= mtime >= mtimecmp;
      if (set_err) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tinymem_sys.sv
// Directed self-checking bench for tinymem_sys using a scoreboard queue.
module tb_tinymem_sys;
    import definitions::*;

    localparam logic [31:0] MEM_BASE  = 32'h0001_0000;
    localparam logic [31:0] MMIO_BASE = 32'hF000_0000;
    localparam int unsigned MEM_WORDS = 16384;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       console_ready;
    logic [7:0] cdata;
    logic       cvalid;
    logic       irq;
    logic       err;

    tinymemif mif ();

    tinymem_sys #(
        .MEM_BASE   (MEM_BASE),
        .MEM_WORDS  (MEM_WORDS),
        .INIT_FILE  (""),
        .MMIO_BASE  (MMIO_BASE),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .memif           (mif),
        .console_data_o  (cdata),
        .console_valid_o (cvalid),
        .console_ready_i (console_ready),
        .timer_irq_o     (irq),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fifo_model[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic sb_compare(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow observed=%h expected=queued_entry", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.value);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic safe_read();
        mif.rd_addr = MEM_BASE;
        mif.rd_size = MEM_ACCESS_SIZE_WORD;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr,
                            input mem_access_size_t size, input logic [31:0] exp);
        mif.rd_addr = addr;
        mif.rd_size = size;
        expect_val(tag, exp);
        @(negedge clk);
        sb_compare(mif.rd_data);
        next();
        safe_read();
    endtask

    task automatic drive_write(input logic [31:0] addr, input mem_access_size_t size,
                               input logic [31:0] data);
        mif.wr_addr   = addr;
        mif.wr_size   = size;
        mif.wr_data   = data;
        mif.wr_enable = 1'b1;
    endtask

    task automatic write(input logic [31:0] addr, input mem_access_size_t size,
                         input logic [31:0] data);
        drive_write(addr, size, data);
        next();
        mif.wr_enable = 1'b0;
    endtask

    task automatic flags_chk(input string tag, input logic v, input logic i, input logic e);
        expect_val({tag, ".valid"}, 32'(v));
        expect_val({tag, ".irq"},   32'(i));
        expect_val({tag, ".err"},   32'(e));
        @(negedge clk);
        sb_compare(32'(cvalid));
        sb_compare(32'(irq));
        sb_compare(32'(err));
        next();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(negedge clk);
        next();
        reset_i = 1'b0;
        fifo_model.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;
        reset_i       = 1'b1;
        console_ready = 1'b0;
        mif.wr_enable = 1'b0;
        mif.wr_addr   = MEM_BASE;
        mif.wr_data   = '0;
        mif.wr_size   = MEM_ACCESS_SIZE_WORD;
        safe_read();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        do_reset();
        read_chk("rst_mtime", MMIO_BASE + 32'h8, MEM_ACCESS_SIZE_WORD, 32'h0000_0001 - 32'h1);
        chk("rst_data", 32'(cdata), 32'h0);
        flags_chk("rst", 1'b0, 1'b0, 1'b0);
        read_chk("rst_mtimecmp", MMIO_BASE + 32'hC, MEM_ACCESS_SIZE_WORD, 32'hFFFF_FFFF);

        // RAM lanes
        write(MEM_BASE, MEM_ACCESS_SIZE_WORD, 32'h0BAD_F00D);
        write(MEM_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'hDEAD_BEEF);
        read_chk("rd_byte5", MEM_BASE + 32'h5, MEM_ACCESS_SIZE_BYTE, 32'h0000_00BE);
        read_chk("rd_half6", MEM_BASE + 32'h6, MEM_ACCESS_SIZE_HALF, 32'h0000_DEAD);
        write(MEM_BASE + 32'h4, MEM_ACCESS_SIZE_BYTE, 32'hFFFF_FF11);
        read_chk("wr_byte4", MEM_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'hDEAD_BE11);
        read_chk("rd_half4", MEM_BASE + 32'h4, MEM_ACCESS_SIZE_HALF, 32'h0000_BE11);
        read_chk("rd_byte7", MEM_BASE + 32'h7, MEM_ACCESS_SIZE_BYTE, 32'h0000_00DE);
        write(MEM_BASE + 32'h6, MEM_ACCESS_SIZE_HALF, 32'h1234_5678);
        read_chk("wr_half6", MEM_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'h5678_BE11);

        // Same-cycle read/write returns the old word
        mif.rd_addr = MEM_BASE + 32'h4;
        expect_val("rw_old", 32'h5678_BE11);
        drive_write(MEM_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'hCAFE_F00D);
        @(negedge clk);
        sb_compare(mif.rd_data);
        next();
        mif.wr_enable = 1'b0;
        read_chk("rw_new", MEM_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'hCAFE_F00D);

        write(MEM_BASE + RAM_LAST(), MEM_ACCESS_SIZE_WORD, 32'h89AB_CDEF);
        read_chk("last_word", MEM_BASE + RAM_LAST(), MEM_ACCESS_SIZE_WORD, 32'h89AB_CDEF);
        flags_chk("ram_ok", 1'b0, 1'b0, 1'b0);

        // Misaligned write is dropped and sticks err_o
        write(MEM_BASE + 32'h1, MEM_ACCESS_SIZE_HALF, 32'h0000_5555);
        flags_chk("mis_wr", 1'b0, 1'b0, 1'b1);
        read_chk("mis_wr_ram", MEM_BASE, MEM_ACCESS_SIZE_WORD, 32'h0BAD_F00D);
        flags_chk("err_hold", 1'b0, 1'b0, 1'b1);

        // Read errors
        do_reset();
        flags_chk("rst2", 1'b0, 1'b0, 1'b0);
        read_chk("oor_rd", MEM_BASE + RAM_LAST() + 32'h4, MEM_ACCESS_SIZE_WORD, 32'h0);
        flags_chk("oor_rd", 1'b0, 1'b0, 1'b1);
        do_reset();
        read_chk("mis_rd", MEM_BASE + 32'h2, MEM_ACCESS_SIZE_WORD, 32'h0);
        flags_chk("mis_rd", 1'b0, 1'b0, 1'b1);
        do_reset();
        read_chk("mmio_byte", MMIO_BASE + 32'h4, MEM_ACCESS_SIZE_BYTE, 32'h0);
        flags_chk("mmio_byte", 1'b0, 1'b0, 1'b1);
        do_reset();
        read_chk("mmio_gap", MMIO_BASE + 32'h10, MEM_ACCESS_SIZE_WORD, 32'h0);
        flags_chk("mmio_gap", 1'b0, 1'b0, 1'b0);
        write(32'h0000_0100, MEM_ACCESS_SIZE_WORD, 32'h1);
        flags_chk("oor_wr", 1'b0, 1'b0, 1'b1);

        // Console FIFO fill
        do_reset();
        read_chk("stat_empty", MMIO_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'h1);
        drive_write(MMIO_BASE, MEM_ACCESS_SIZE_WORD, 32'hFFFF_FFA0);
        fifo_model.push_back(8'hA0);
        expect_val("no_bypass", 32'h0);
        @(negedge clk);
        sb_compare(32'(cvalid));
        next();
        mif.wr_enable = 1'b0;
        expect_val("head_first", 32'h0000_00A0);
        @(negedge clk);
        sb_compare(32'(cdata));
        for (int i = 1; i < 8; i++) begin
            write(MMIO_BASE, MEM_ACCESS_SIZE_WORD, 32'(8'hA0 + i));
            fifo_model.push_back(8'(8'hA0 + i));
        end
        read_chk("stat_full", MMIO_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'h2);
        flags_chk("full", 1'b1, 1'b0, 1'b0);
        write(MMIO_BASE, MEM_ACCESS_SIZE_WORD, 32'h0000_00C9);
        flags_chk("drop", 1'b1, 1'b0, 1'b1);
        read_chk("stat_drop", MMIO_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'h2);

        // Push into a full FIFO while popping
        console_ready = 1'b1;
        drive_write(MMIO_BASE, MEM_ACCESS_SIZE_WORD, 32'h0000_00B9);
        @(negedge clk);
        chk("pop_push_head", 32'(cdata), 32'(fifo_model.pop_front()));
        next();
        mif.wr_enable = 1'b0;
        console_ready = 1'b0;
        fifo_model.push_back(8'hB9);
        read_chk("stat_still_full", MMIO_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'h2);

        // Drain with ready toggling
        budget = 0;
        while (fifo_model.size() > 0 && budget < 100) begin
            console_ready = budget[0];
            @(negedge clk);
            if (cvalid && console_ready) chk("drain", 32'(cdata), 32'(fifo_model.pop_front()));
            next();
            budget++;
        end
        console_ready = 1'b0;
        chk("drain_left", 32'(fifo_model.size()), 32'h0);
        chk("drained_data", 32'(cdata), 32'h0);
        flags_chk("drained", 1'b0, 1'b0, 1'b1);
        read_chk("stat_drained", MMIO_BASE + 32'h4, MEM_ACCESS_SIZE_WORD, 32'h1);

        // Timer compare and MTIME overwrite
        do_reset();
        write(MMIO_BASE + 32'hC, MEM_ACCESS_SIZE_WORD, 32'd20);
        mif.rd_addr = MMIO_BASE + 32'h8;
        for (int n = 1; n < 20; n++) begin
            expect_val("mtime_count", 32'(n));
            @(negedge clk);
            sb_compare(mif.rd_data);
            next();
        end
        expect_val("mtime_20", 32'd20);
        expect_val("irq_pre", 32'h0);
        drive_write(MMIO_BASE + 32'h8, MEM_ACCESS_SIZE_WORD, 32'h0);
        @(negedge clk);
        sb_compare(mif.rd_data);
        sb_compare(32'(irq));
        next();
        mif.wr_enable = 1'b0;
        expect_val("irq_rise", 32'h1);
        expect_val("mtime_load", 32'h0);
        @(negedge clk);
        sb_compare(32'(irq));
        sb_compare(mif.rd_data);
        next();
        expect_val("irq_fall", 32'h0);
        expect_val("mtime_resume", 32'h1);
        @(negedge clk);
        sb_compare(32'(irq));
        sb_compare(mif.rd_data);
        next();
        safe_read();

        // Asynchronous reset mid-drain
        do_reset();
        for (int i = 0; i < 3; i++) begin
            write(MMIO_BASE, MEM_ACCESS_SIZE_WORD, 32'(8'h31 + i));
            fifo_model.push_back(8'(8'h31 + i));
        end
        write(MMIO_BASE + 32'hC, MEM_ACCESS_SIZE_WORD, 32'h0);
        read_chk("pre_mis", MEM_BASE + 32'h1, MEM_ACCESS_SIZE_WORD, 32'h0);
        flags_chk("pre_rst", 1'b1, 1'b1, 1'b1);
        console_ready = 1'b1;
        @(negedge clk);
        chk("pre_rst_pop", 32'(cdata), 32'(fifo_model.pop_front()));
        next();
        mif.rd_addr = MMIO_BASE + 32'h8;
        #2 reset_i = 1'b1;
        #1;
        chk("arst_valid", 32'(cvalid), 32'h0);
        chk("arst_irq",   32'(irq),    32'h0);
        chk("arst_err",   32'(err),    32'h0);
        chk("arst_data",  32'(cdata),  32'h0);
        chk("arst_mtime", mif.rd_data, 32'h0);
        next();
        reset_i = 1'b0;
        console_ready = 1'b0;
        safe_read();
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [31:0] RAM_LAST();
        return 32'(MEM_WORDS * 4) - 32'h4;
    endfunction

endmodule
